// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bus: imem request/response, redirect/stop control and the IF/ID head port.
interface mips_fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            inst_req;
   logic [XLEN-1:0] inst_addr;
   logic            inst_valid;
   logic [XLEN-1:0] inst;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            stop;
   logic            deq_ready;
   logic            out_valid;
   logic [XLEN-1:0] out_inst;
   logic [XLEN-1:0] out_pcp4;
   logic [CW-1:0]   count;

   modport master (
      output inst_req, inst_addr, out_valid, out_inst, out_pcp4, count,
      input  inst_valid, inst, redirect, redirect_pc, stop, deq_ready
   );

   modport slave (
      input  inst_req, inst_addr, out_valid, out_inst, out_pcp4, count,
      output inst_valid, inst, redirect, redirect_pc, stop, deq_ready
   );
endinterface

// File: rtl/mips_fetch_queue.sv
// MIPS instruction-fetch front end: PC owner, single-outstanding imem requester, DEPTH-entry queue.
// Optional FETCHQ_BYPASS_EN forwards a response straight to the head port when the queue is empty.
module mips_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst_b,
   mips_fetch_queue_if.master bus
);
   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW:0]     DEPTH_X = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            run_q, run_d;
   logic [XLEN-1:0] hold_inst_q, hold_inst_d;
   logic [XLEN-1:0] hold_pcp4_q, hold_pcp4_d;
   logic [XLEN-1:0] mem_inst_q [DEPTH];
   logic [XLEN-1:0] mem_pcp4_q [DEPTH];

   logic [XLEN-1:0] pc_plus4;
   logic            fifo_nempty;
   logic            resp_ok;
   logic            push;
   logic            pop;
   logic            fifo_pop;
   logic [CW:0]     occ_next;
   logic            free_slot;
   logic            out_valid;
   logic [XLEN-1:0] out_inst;
   logic [XLEN-1:0] out_pcp4;
   logic            inst_req;
   logic [XLEN-1:0] inst_addr;

   assign pc_plus4    = pc_q + XLEN'(4);
   assign fifo_nempty = (count_q != '0);
   assign resp_ok     = (state_q == WAIT) && bus.inst_valid && !bus.redirect;

`ifdef FETCHQ_BYPASS_EN
   logic byp;
   assign byp  = resp_ok && !fifo_nempty;
   // A bypassed word that IF/ID takes right away never occupies a slot.
   assign push = resp_ok && !(byp && bus.deq_ready);
`else
   assign push = resp_ok;
`endif

   always_comb begin
      out_valid = fifo_nempty;
      out_inst  = hold_inst_q;
      out_pcp4  = hold_pcp4_q;
      if (fifo_nempty) begin
         out_inst = mem_inst_q[head_q];
         out_pcp4 = mem_pcp4_q[head_q];
      end
`ifdef FETCHQ_BYPASS_EN
      else if (byp) begin
         out_valid = 1'b1;
         out_inst  = bus.inst;
         out_pcp4  = pc_plus4;
      end
`endif
   end

   assign pop      = out_valid && bus.deq_ready;
   assign fifo_pop = pop && fifo_nempty;
   assign occ_next = {1'b0, count_q} + (CW+1)'(push) - (CW+1)'(fifo_pop);
   assign free_slot = (occ_next < DEPTH_X);

   // run_q keeps the first cycle after reset quiet so a stale response cannot race a new request.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_req  = 1'b0;
      inst_addr = pc_q;
      run_d     = 1'b1;
      case (state_q)
         IDLE: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
            end else if (run_q && !bus.stop && free_slot) begin
               inst_req = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_pc;
               state_d = bus.inst_valid ? IDLE : DROP;
            end else if (bus.inst_valid) begin
               pc_d      = pc_plus4;
               inst_addr = pc_plus4;
               if (!bus.stop && free_slot) begin
                  inst_req = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
            end
            if (bus.inst_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      hold_inst_d = out_valid ? out_inst : hold_inst_q;
      hold_pcp4_d = out_valid ? out_pcp4 : hold_pcp4_q;
      if (bus.redirect) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + PW'(1);
         end
         if (fifo_pop) begin
            head_d = head_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(fifo_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         run_q       <= 1'b0;
         hold_inst_q <= '0;
         hold_pcp4_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         run_q       <= run_d;
         hold_inst_q <= hold_inst_d;
         hold_pcp4_q <= hold_pcp4_d;
      end
   end

   // Queue storage is pure data; validity is carried by count/head/tail.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst_q[tail_q] <= bus.inst;
         mem_pcp4_q[tail_q] <= pc_plus4;
      end
   end

   assign bus.inst_req  = inst_req;
   assign bus.inst_addr = inst_addr;
   assign bus.out_valid = out_valid;
   assign bus.out_inst  = out_inst;
   assign bus.out_pcp4  = out_pcp4;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Self-checking bench for mips_fetch_queue: imem model with tagged requests and an expected-queue scoreboard.
module tb_mips_fetch_queue;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0400;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   mips_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   mips_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pcp4;
   } ent_t;

   typedef struct {
      string name;
      bit    stop;
      bit    deq;
      int    lat;
      int    cycles;
      int    exp_count;
      bit    exp_req;
   } phase_t;

   ent_t        sb[$];
   phase_t      phases[4];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          pend = 0;
   int          pwait = 0;
   logic [31:0] paddr = '0;
   int          ptag = 0;
   int          epoch = 0;
   int          lat = 1;
   logic [31:0] exp_pc = RPC;
   logic [31:0] hold_inst = '0;
   logic [31:0] hold_pcp4 = '0;
   bit          force_valid = 0;
   bit          rsp_model = 0;
   logic [31:0] rsp_addr = '0;
   int          rsp_tag = 0;
   int          last_count = 0;
   bit          last_req = 0;
   bit          last_ov = 0;
   logic [31:0] last_addr = '0;
   logic [31:0] last_pcp4 = '0;
   int          n_pops = 0;
   int          n_reqs = 0;
   int          p0, r0;

   function automatic logic [31:0] ifun(logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      epoch++;
      pend      = 0;
      exp_pc    = RPC;
      hold_inst = '0;
      hold_pcp4 = '0;
   endtask

   // One clock cycle: entered just after a rising edge, drives imem, checks at the falling edge.
   task automatic step();
      bit accepted;
      rsp_model = 0;
      if (pend) begin
         if (pwait == 0) begin
            rsp_model = 1;
            rsp_addr  = paddr;
            rsp_tag   = ptag;
            pend      = 0;
         end else begin
            pwait--;
         end
      end
      bus.inst_valid = rsp_model | force_valid;
      bus.inst       = rsp_model ? ifun(rsp_addr) : $urandom();
      @(negedge clk);
      accepted   = rsp_model && (rsp_tag == epoch) && !bus.redirect;
      last_count = int'(bus.count);
      last_req   = bus.inst_req;
      last_ov    = bus.out_valid;
      last_addr  = bus.inst_addr;
      last_pcp4  = bus.out_pcp4;
      chk("count", 32'(bus.count), 32'(sb.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk("out_inst", bus.out_inst, sb[0].inst);
         chk("out_pcp4", bus.out_pcp4, sb[0].pcp4);
         hold_inst = sb[0].inst;
         hold_pcp4 = sb[0].pcp4;
      end else begin
         chk("hold_inst", bus.out_inst, hold_inst);
         chk("hold_pcp4", bus.out_pcp4, hold_pcp4);
      end
      chk("req_during_redirect", 32'(bus.inst_req && bus.redirect), 32'd0);
      chk("req_during_stop", 32'(bus.inst_req && bus.stop), 32'd0);
      chk("req_while_outstanding", 32'(bus.inst_req && pend), 32'd0);
      if (bus.redirect) begin
         sb.delete();
         epoch++;
         exp_pc = bus.redirect_pc;
      end else if (sb.size() != 0 && bus.deq_ready) begin
         void'(sb.pop_front());
         n_pops++;
      end
      if (accepted) begin
         sb.push_back('{inst: ifun(rsp_addr), pcp4: rsp_addr + 32'd4});
         exp_pc = rsp_addr + 32'd4;
      end
      if (bus.inst_req) begin
         n_reqs++;
         chk("inst_addr", bus.inst_addr, exp_pc);
         pend  = 1;
         pwait = lat - 1;
         paddr = exp_pc;
         ptag  = epoch;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      phases[0] = '{name: "fill_stream", stop: 1'b0, deq: 1'b1, lat: 1, cycles: 7,  exp_count: 4'd1, exp_req: 1'b1};
      phases[1] = '{name: "fill_full",   stop: 1'b0, deq: 1'b0, lat: 1, cycles: 8,  exp_count: 4'd4, exp_req: 1'b0};
      phases[2] = '{name: "first_pop",   stop: 1'b0, deq: 1'b1, lat: 3, cycles: 1,  exp_count: 4'd4, exp_req: 1'b1};
      phases[3] = '{name: "drain_lat3",  stop: 1'b0, deq: 1'b1, lat: 3, cycles: 12, exp_count: 4'd0, exp_req: 1'b1};

      rst_b           = 1'b0;
      bus.inst_valid  = 1'b0;
      bus.inst        = '0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.stop        = 1'b0;
      bus.deq_ready   = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_inst_req",  32'(bus.inst_req), 32'd0);
      chk("rst_inst_addr", bus.inst_addr, RPC);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_inst",  bus.out_inst, 32'd0);
      chk("rst_out_pcp4",  bus.out_pcp4, 32'd0);
      chk("rst_count",     32'(bus.count), 32'd0);

      // First cycle out of reset: a stray response is ignored and nothing is requested.
      rst_b       = 1'b1;
      force_valid = 1;
      step();
      force_valid = 0;
      chk("first_cycle_no_req", 32'(last_req), 32'd0);

      for (int p = 0; p < 4; p++) begin
         bus.stop      = phases[p].stop;
         bus.deq_ready = phases[p].deq;
         lat           = phases[p].lat;
         repeat (phases[p].cycles) step();
         chk({phases[p].name, "_count"}, 32'(last_count), 32'(phases[p].exp_count));
         chk({phases[p].name, "_req"},   32'(last_req),   32'(phases[p].exp_req));
      end

      // Redirect while a request is outstanding: the late response must be dropped.
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_2000;
      step();
      bus.redirect = 1'b0;
      step();
      chk("redirect_flush_count", 32'(last_count), 32'd0);
      for (int i = 0; i < 10 && !last_req; i++) step();
      chk("redirect_req",  32'(last_req), 32'd1);
      chk("redirect_addr", last_addr, 32'h0000_2000);
      for (int i = 0; i < 10 && !last_ov; i++) step();
      chk("redirect_valid",      32'(last_ov), 32'd1);
      chk("redirect_first_pcp4", last_pcp4, 32'h0000_2004);

      // Redirect coincident with a response and a pop.
      lat           = 1;
      bus.deq_ready = 1'b0;
      for (int i = 0; i < 20 && !(last_count >= 2 && pend && pwait == 0); i++) step();
      chk("coincident_setup", 32'(last_count >= 2 && pend && pwait == 0), 32'd1);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_3000;
      bus.deq_ready   = 1'b1;
      step();
      bus.redirect = 1'b0;
      step();
      chk("coincident_count", 32'(last_count), 32'd0);
      chk("coincident_req",   32'(last_req), 32'd1);
      chk("coincident_addr",  last_addr, 32'h0000_3000);

      // stop with a request in flight: its word still arrives, nothing new issues.
      lat = 3;
      step();
      chk("stop_setup_req", 32'(last_req), 32'd1);
      bus.stop = 1'b1;
      p0 = n_pops;
      r0 = n_reqs;
      repeat (6) step();
      chk("stop_drain_pops", 32'(n_pops - p0), 32'd2);
      chk("stop_no_req",     32'(n_reqs - r0), 32'd0);
      bus.stop = 1'b0;
      step();
      chk("resume_req",  32'(last_req), 32'd1);
      chk("resume_addr", last_addr, 32'h0000_3008);

      // Asynchronous reset mid-WAIT with three entries queued.
      lat           = 2;
      bus.deq_ready = 1'b0;
      for (int i = 0; i < 20 && last_count != 3; i++) step();
      chk("reset_setup_count", 32'(last_count), 32'd3);
      #2;
      rst_b = 1'b0;
      #1;
      chk("async_rst_count",     32'(bus.count), 32'd0);
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_inst_addr", bus.inst_addr, RPC);
      chk("async_rst_inst_req",  32'(bus.inst_req), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_b       = 1'b1;
      force_valid = 1;
      step();
      force_valid = 0;
      chk("late_valid_no_req", 32'(last_req), 32'd0);
      bus.deq_ready = 1'b1;
      lat           = 1;
      step();
      chk("late_valid_not_enqueued", 32'(last_count), 32'd0);
      chk("restart_req",  32'(last_req), 32'd1);
      chk("restart_addr", last_addr, RPC);
      repeat (6) step();
      chk("restart_count", 32'(last_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_fetch_queue.md
Name: mips_fetch_queue

Overview:
Parametrised instruction-fetch front end for the next-generation pipelined MIPS core. It owns the PC and issues requests to a variable-latency instruction memory with at most one request outstanding. Returned words are buffered with their PC+4 in a DEPTH-entry FIFO that feeds the IF/ID register. Branch/jump redirects from the MEM stage flush the FIFO and discard any in-flight response.

Parameters:
XLEN, 32, width of PC, instruction and PC+4 fields
DEPTH, 4, FIFO entries; power of two, minimum 2
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_b  input  1  asynchronous active-low reset
inst_req  output  1  fetch request strobe, one cycle per request
inst_addr  output  XLEN  fetch address, valid while inst_req=1
inst_valid  input  1  response strobe for the single outstanding request
inst  input  XLEN  instruction word, valid with inst_valid
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  XLEN  new PC, sampled when redirect=1
stop  input  1  halt issue of new requests; buffered entries still drain
deq_ready  input  1  IF/ID accepts the head entry
out_valid  output  1  head entry valid
out_inst  output  XLEN  head instruction
out_pcp4  output  XLEN  head PC+4
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_b=0): pc=RESET_PC, FIFO empty, state=IDLE. inst_req=0, inst_addr=RESET_PC, out_valid=0, out_inst=0, out_pcp4=0, count=0. Reset mid-request: the outstanding response is forgotten. Any inst_valid in the first cycle after reset is ignored.
- Dequeue: pop = out_valid & deq_ready. The head advances on the next edge.
- Free slot for issue: (count - pop + push) < DEPTH, where push is the enqueue in the same cycle.
- State IDLE: if !stop & !redirect & free slot: inst_req=1, inst_addr=pc, go to WAIT.
- State WAIT (request outstanding):
  - On inst_valid & !redirect: push {inst, pc+4} and set pc<=pc+4.
  - In that same cycle, if !stop and a free slot remains, issue the next request back-to-back with inst_addr=pc+4 and stay in WAIT; otherwise go to IDLE.
  - The steady-state rate is one instruction per imem latency.
- State DROP: wait for inst_valid, discard the word, go to IDLE. A redirect arriving while in DROP updates pc and stays in DROP.
- Redirect (highest priority, any state): FIFO emptied (count=0 next cycle, pop ignored), pc<=redirect_pc, no request issued that cycle.
  - WAIT without inst_valid -> DROP.
  - WAIT with inst_valid in the same cycle -> word discarded, IDLE.
  - IDLE -> IDLE.
- Full: count=DEPTH and no pop -> no issue. Push never occurs when full, by construction of the free-slot rule.
- Empty: out_valid=0. out_inst and out_pcp4 hold their last values.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. pc+4 wraps modulo 2^XLEN.
- Simultaneous push and pop: count unchanged, both pointers advance.
- stop does not cancel an outstanding request: its response is still enqueued.

Optional Feature:
FETCHQ_BYPASS_EN
- Defined: when the FIFO is empty and in WAIT, inst_valid without redirect drives out_valid=1, out_inst=inst and out_pcp4=pc+4 combinationally in the same cycle. If deq_ready=1 the word is consumed and not written to the FIFO. This gives zero-cycle fetch-to-IF/ID latency.
- Undefined: every word is written to the FIFO first, so out_valid rises at the earliest one cycle after inst_valid.

Test Plan:
- Reset with RESET_PC=0x400, deq_ready=1, imem latency 1 -> inst_req at 0x400, 0x404, 0x408 on consecutive response cycles; out_pcp4 sequence 0x404, 0x408, 0x40C; count<=1.
- deq_ready=0, DEPTH=4 -> exactly 4 words enqueued, count=4, inst_req stays 0. Raise deq_ready -> the 5th request issues in the same cycle as the first pop.
- Redirect to 0x2000 while WAIT, response 3 cycles later -> that response is dropped, count=0, next inst_addr=0x2000, first out_pcp4=0x2004.
- Redirect coincident with inst_valid and a pop -> count=0 next cycle, word not enqueued, next request at redirect_pc.
- stop=1 while a request is outstanding -> its response is enqueued, no further inst_req. Clear stop -> fetch resumes at the next sequential PC.
- rst_b pulsed low mid-WAIT with count=3 -> count=0, out_valid=0, inst_addr=RESET_PC asynchronously. A late inst_valid is not enqueued.
